// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared types and constants for the multicycle MIPS controller.
//   state_t     - controller state encoding (FETCH=0 .. BNEEX=12)
//   OP_*        - instruction opcodes (IR[31:26])
//   FN_*        - R-type function codes (IR[5:0])
//   aluop_t     - FSM-to-ALU-decoder operation class
//   ALUC_*      - ALU control encodings
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11,
    BNEEX   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  localparam logic [2:0] ALUC_AND = 3'b000;
  localparam logic [2:0] ALUC_OR  = 3'b001;
  localparam logic [2:0] ALUC_ADD = 3'b010;
  localparam logic [2:0] ALUC_SUB = 3'b110;
  localparam logic [2:0] ALUC_SLT = 3'b111;

endpackage

// File: rtl/mips_multicycle_ctrl_alu_dec.sv
// alu_dec: combinational ALU decoder.
//   aluop         in  operation class from the controller FSM
//   funct         in  R-type function field
//   alucontrol    out ALU operation select
//   illegal_funct out high when aluop selects funct decoding and funct is unknown
module alu_dec
  import mips_ctrl_pkg::*;
(
  input  aluop_t     aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol,
  output logic       illegal_funct
);

  // Map operation class (and funct for R-type) to the ALU control code.
  always_comb begin
    alucontrol    = ALUC_ADD;
    illegal_funct = 1'b0;
    case (aluop)
      ALUOP_ADD: alucontrol = ALUC_ADD;
      ALUOP_SUB: alucontrol = ALUC_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alucontrol = ALUC_ADD;
          FN_SUB:  alucontrol = ALUC_SUB;
          FN_AND:  alucontrol = ALUC_AND;
          FN_OR:   alucontrol = ALUC_OR;
          FN_SLT:  alucontrol = ALUC_SLT;
          default: begin
            // Unknown funct still yields an add so the datapath stays defined.
            alucontrol    = ALUC_ADD;
            illegal_funct = 1'b1;
          end
        endcase
      end
      default: alucontrol = ALUC_ADD;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: Moore control FSM for the multicycle MIPS datapath.
// Optional feature macro: MIPS_CTRL_BNE_EN (adds bne via state BNEEX=12).
// Ports:
//   clk, rst      clock (rising edge) and synchronous active-high reset
//   op, funct     instruction opcode and function field
//   zero          ALU zero flag (branch resolution)
//   iord, memwrite, irwrite, regdst, memtoreg, regwrite,
//   alusrca, alusrcb, pcsrc, alucontrol, pcen   datapath controls
//   illegal       one-cycle pulse on an undecodable op/funct
//   dbg_state     current state encoding
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         op,
  input  logic [5:0]         funct,
  input  logic               zero,
  output logic               iord,
  output logic               memwrite,
  output logic               irwrite,
  output logic               regdst,
  output logic               memtoreg,
  output logic               regwrite,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic [1:0]         pcsrc,
  output logic [2:0]         alucontrol,
  output logic               pcen,
  output logic               illegal,
  output logic [STATE_W-1:0] dbg_state
);

  state_t state_r;
  state_t next_state_s;

  aluop_t aluop_s;
  logic   pcwrite_s;
  logic   branch_s;
  logic   branch_ne_s;
  logic   illegal_op_s;
  logic   illegal_funct_s;
  logic   irwrite_s;
  logic   memwrite_s;
  logic   regwrite_s;

  // State register; reset returns to FETCH and abandons any in-flight instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and per-state raw controls (before reset gating).
  always_comb begin
    next_state_s = FETCH;
    aluop_s      = ALUOP_ADD;
    pcwrite_s    = 1'b0;
    branch_s     = 1'b0;
    branch_ne_s  = 1'b0;
    illegal_op_s = 1'b0;
    irwrite_s    = 1'b0;
    memwrite_s   = 1'b0;
    regwrite_s   = 1'b0;
    iord         = 1'b0;
    regdst       = 1'b0;
    memtoreg     = 1'b0;
    alusrca      = 1'b0;
    alusrcb      = 2'b00;
    pcsrc        = 2'b00;
    case (state_r)
      FETCH: begin
        alusrcb      = 2'b01;
        irwrite_s    = 1'b1;
        pcwrite_s    = 1'b1;
        next_state_s = DECODE;
      end
      DECODE: begin
        // Branch target (PC+4 + offset<<2) is precomputed here into ALUOut.
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW: next_state_s = MEMADR;
          OP_RTYPE:     next_state_s = RTYPEEX;
          OP_BEQ:       next_state_s = BEQEX;
          OP_ADDI:      next_state_s = ADDIEX;
          OP_J:         next_state_s = JEX;
`ifdef MIPS_CTRL_BNE_EN
          OP_BNE:       next_state_s = BNEEX;
`endif
          default: begin
            next_state_s = FETCH;
            illegal_op_s = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        if (op == OP_SW) begin
          next_state_s = MEMWR;
        end else begin
          next_state_s = MEMRD;
        end
      end
      MEMRD: begin
        iord         = 1'b1;
        next_state_s = MEMWB;
      end
      MEMWB: begin
        regwrite_s   = 1'b1;
        memtoreg     = 1'b1;
        next_state_s = FETCH;
      end
      MEMWR: begin
        iord         = 1'b1;
        memwrite_s   = 1'b1;
        next_state_s = FETCH;
      end
      RTYPEEX: begin
        alusrca      = 1'b1;
        aluop_s      = ALUOP_FUNCT;
        next_state_s = RTYPEWB;
      end
      RTYPEWB: begin
        regdst       = 1'b1;
        regwrite_s   = 1'b1;
        next_state_s = FETCH;
      end
      BEQEX: begin
        alusrca      = 1'b1;
        aluop_s      = ALUOP_SUB;
        branch_s     = 1'b1;
        pcsrc        = 2'b01;
        next_state_s = FETCH;
      end
      ADDIEX: begin
        alusrca      = 1'b1;
        alusrcb      = 2'b10;
        next_state_s = ADDIWB;
      end
      ADDIWB: begin
        regwrite_s   = 1'b1;
        next_state_s = FETCH;
      end
      JEX: begin
        pcsrc        = 2'b10;
        pcwrite_s    = 1'b1;
        next_state_s = FETCH;
      end
`ifdef MIPS_CTRL_BNE_EN
      BNEEX: begin
        alusrca      = 1'b1;
        aluop_s      = ALUOP_SUB;
        branch_ne_s  = 1'b1;
        pcsrc        = 2'b01;
        next_state_s = FETCH;
      end
`endif
      default: begin
        // Unused encodings recover to FETCH with every enable low.
        next_state_s = FETCH;
      end
    endcase
  end

  alu_dec u_alu_dec (
    .aluop         (aluop_s),
    .funct         (funct),
    .alucontrol    (alucontrol),
    .illegal_funct (illegal_funct_s)
  );

  // Enable outputs; reset suppresses every write so no partial update escapes.
  always_comb begin
    irwrite  = 1'b0;
    memwrite = 1'b0;
    regwrite = 1'b0;
    pcen     = 1'b0;
    illegal  = 1'b0;
    if (rst) begin
      irwrite  = 1'b0;
      memwrite = 1'b0;
      regwrite = 1'b0;
      pcen     = 1'b0;
      illegal  = 1'b0;
    end else begin
      irwrite  = irwrite_s;
      memwrite = memwrite_s;
      regwrite = regwrite_s;
`ifdef MIPS_CTRL_BNE_EN
      pcen     = pcwrite_s | (branch_s & zero) | (branch_ne_s & ~zero);
`else
      pcen     = pcwrite_s | (branch_s & zero);
`endif
      illegal  = illegal_op_s | ((state_r == RTYPEEX) & illegal_funct_s);
    end
  end

  assign dbg_state = STATE_W'(state_r);

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed self-checking bench for mips_multicycle_ctrl.
module tb_mips_multicycle_ctrl;

  logic       clk;
  logic       rst;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic       pcen, illegal;
  logic [3:0] dbg_state;

  int checks = 0;
  int errors = 0;

  mips_multicycle_ctrl #(.STATE_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .iord       (iord),
    .memwrite   (memwrite),
    .irwrite    (irwrite),
    .regdst     (regdst),
    .memtoreg   (memtoreg),
    .regwrite   (regwrite),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .pcsrc      (pcsrc),
    .alucontrol (alucontrol),
    .pcen       (pcen),
    .illegal    (illegal),
    .dbg_state  (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Packs all write enables: {irwrite,pcen,regwrite,memwrite,illegal}
  function automatic logic [31:0] ens();
    return 32'({irwrite, pcen, regwrite, memwrite, illegal});
  endfunction

  initial begin
    rst = 1'b1; op = 6'b100011; funct = 6'b000000; zero = 1'b0;

    // Reset: two cycles, no enables asserted.
    tick();
    chk("rst_state0", 32'(dbg_state), 32'd0);
    chk("rst_ens0", ens(), 32'd0);
    tick();
    chk("rst_ens1", ens(), 32'd0);
    rst = 1'b0;
    #1;

    // lw: 0,1,2,3,4,0
    chk("lw_fetch_state", 32'(dbg_state), 32'd0);
    chk("lw_fetch_ens", ens(), 32'b11000);
    chk("lw_fetch_srcb", 32'(alusrcb), 32'd1);
    chk("lw_fetch_aluc", 32'(alucontrol), 32'd2);
    tick();
    chk("lw_dec_state", 32'(dbg_state), 32'd1);
    chk("lw_dec_srcb", 32'(alusrcb), 32'd3);
    chk("lw_dec_ens", ens(), 32'd0);
    tick();
    chk("lw_memadr_state", 32'(dbg_state), 32'd2);
    chk("lw_memadr_srca", 32'(alusrca), 32'd1);
    chk("lw_memadr_srcb", 32'(alusrcb), 32'd2);
    chk("lw_memadr_memtoreg", 32'(memtoreg), 32'd0);
    tick();
    chk("lw_memrd_state", 32'(dbg_state), 32'd3);
    chk("lw_memrd_iord", 32'(iord), 32'd1);
    chk("lw_memrd_regwrite", 32'(regwrite), 32'd0);
    tick();
    chk("lw_memwb_state", 32'(dbg_state), 32'd4);
    chk("lw_memwb_memtoreg", 32'(memtoreg), 32'd1);
    chk("lw_memwb_ens", ens(), 32'b00100);
    tick();
    chk("lw_done_state", 32'(dbg_state), 32'd0);

    // R-type slt
    op = 6'b000000; funct = 6'b101010;
    tick();
    chk("r_dec_state", 32'(dbg_state), 32'd1);
    tick();
    chk("r_ex_state", 32'(dbg_state), 32'd6);
    chk("r_ex_aluc", 32'(alucontrol), 32'b111);
    chk("r_ex_srca", 32'(alusrca), 32'd1);
    chk("r_ex_illegal", 32'(illegal), 32'd0);
    tick();
    chk("r_wb_state", 32'(dbg_state), 32'd7);
    chk("r_wb_regdst", 32'(regdst), 32'd1);
    chk("r_wb_ens", ens(), 32'b00100);
    tick();
    chk("r_done_state", 32'(dbg_state), 32'd0);

    // R-type with unknown funct: add + illegal, still proceeds to RTYPEWB
    funct = 6'b111111;
    tick(); tick();
    chk("rbad_ex_aluc", 32'(alucontrol), 32'b010);
    chk("rbad_ex_illegal", 32'(illegal), 32'd1);
    tick();
    chk("rbad_wb_state", 32'(dbg_state), 32'd7);
    chk("rbad_wb_illegal", 32'(illegal), 32'd0);
    tick();

    // beq taken
    op = 6'b000100; zero = 1'b1;
    tick(); tick();
    chk("beq_t_state", 32'(dbg_state), 32'd8);
    chk("beq_t_pcsrc", 32'(pcsrc), 32'd1);
    chk("beq_t_pcen", 32'(pcen), 32'd1);
    chk("beq_t_aluc", 32'(alucontrol), 32'b110);
    tick();
    chk("beq_t_done", 32'(dbg_state), 32'd0);

    // beq not taken
    zero = 1'b0;
    tick(); tick();
    chk("beq_n_state", 32'(dbg_state), 32'd8);
    chk("beq_n_pcen", 32'(pcen), 32'd0);
    tick();
    chk("beq_n_done", 32'(dbg_state), 32'd0);

    // jump
    op = 6'b000010;
    tick(); tick();
    chk("j_state", 32'(dbg_state), 32'd11);
    chk("j_pcsrc", 32'(pcsrc), 32'd2);
    chk("j_pcen", 32'(pcen), 32'd1);
    tick();
    chk("j_done", 32'(dbg_state), 32'd0);

    // addi
    op = 6'b001000;
    tick(); tick();
    chk("addi_ex_state", 32'(dbg_state), 32'd9);
    chk("addi_ex_srcb", 32'(alusrcb), 32'd2);
    tick();
    chk("addi_wb_state", 32'(dbg_state), 32'd10);
    chk("addi_wb_ens", ens(), 32'b00100);
    chk("addi_wb_regdst", 32'(regdst), 32'd0);
    tick();

    // illegal opcode: one-cycle pulse in DECODE
    op = 6'b111111;
    tick();
    chk("ill_dec_illegal", 32'(illegal), 32'd1);
    tick();
    chk("ill_back_state", 32'(dbg_state), 32'd0);
    chk("ill_back_illegal", 32'(illegal), 32'd0);

    // sw with reset asserted during MEMWR
    op = 6'b101011;
    tick(); tick(); tick();
    chk("sw_memwr_state", 32'(dbg_state), 32'd5);
    chk("sw_memwr_memwrite", 32'(memwrite), 32'd1);
    rst = 1'b1;
    #1;
    chk("sw_rst_memwrite", 32'(memwrite), 32'd0);
    chk("sw_rst_ens", ens(), 32'd0);
    tick();
    chk("sw_rst_state", 32'(dbg_state), 32'd0);
    rst = 1'b0;
    #1;

    // bne
    op = 6'b000101; zero = 1'b0;
    tick();
`ifdef MIPS_CTRL_BNE_EN
    chk("bne_dec_illegal", 32'(illegal), 32'd0);
    tick();
    chk("bne_state", 32'(dbg_state), 32'd12);
    chk("bne_pcen", 32'(pcen), 32'd1);
    chk("bne_pcsrc", 32'(pcsrc), 32'd1);
    zero = 1'b1;
    #1;
    chk("bne_nt_pcen", 32'(pcen), 32'd0);
    tick();
    chk("bne_done", 32'(dbg_state), 32'd0);
`else
    chk("bne_dec_illegal", 32'(illegal), 32'd1);
    tick();
    chk("bne_done", 32'(dbg_state), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
